// File: rtl/fpga_config_loader.sv
// Serializes host words LSB first onto the fabric configuration scan chain.
// Define CFG_READBACK_EN to capture the chain tail and return the old configuration.
module fpga_config_loader #(
    parameter int unsigned CHAIN_LEN = 12,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_scan_out,
    output logic              cfg_scan_en,
    input  logic              cfg_scan_in,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int unsigned RW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned CW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {StIdle, StWaitWord, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] word_q;
    logic [RW-1:0]     rem_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     n_word;
    logic              accept;
    logic              last_bit;

    assign accept   = (state_q == StWaitWord) && in_valid;
    assign last_bit = (state_q == StShift) && (cnt_q == CW'(1));

    // Bits taken from the next word: a full word, or whatever remains of the chain.
    always_comb begin
        if (int'(rem_q) >= int'(WORD_W)) begin
            n_word = CW'(WORD_W);
        end else begin
            n_word = CW'(rem_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = StWaitWord;
            StWaitWord: if (in_valid) state_d = StShift;
            StShift: begin
                if (cnt_q == CW'(1)) begin
                    state_d = (rem_q == RW'(1)) ? StDone : StWaitWord;
                end
            end
            StDone:     if (start) state_d = StWaitWord;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StWaitWord);
        busy     = (state_q == StWaitWord) || (state_q == StShift);
        done     = (state_q == StDone);
    end

    // Bit 0 leaves on the accept edge so the first SHIFT cycle already carries it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q       <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            cfg_scan_out <= 1'b0;
            cfg_scan_en  <= 1'b0;
        end else begin
            if (start && ((state_q == StIdle) || (state_q == StDone))) begin
                rem_q <= RW'(CHAIN_LEN);
            end
            if (accept) begin
                word_q       <= in_data >> 1;
                cnt_q        <= n_word;
                cfg_scan_out <= in_data[0];
                cfg_scan_en  <= 1'b1;
            end else if (state_q == StShift) begin
                rem_q <= rem_q - RW'(1);
                cnt_q <= cnt_q - CW'(1);
                if (last_bit) begin
                    cfg_scan_out <= 1'b0;
                    cfg_scan_en  <= 1'b0;
                end else begin
                    cfg_scan_out <= word_q[0];
                    word_q       <= word_q >> 1;
                    cfg_scan_en  <= 1'b1;
                end
            end
        end
    end

`ifdef CFG_READBACK_EN
    localparam int unsigned IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [IW-1:0]     rb_idx_q;
    logic [WORD_W-1:0] rb_acc_q, rb_acc_d;

    // Tail bit is the old chain content, captured on the same edge the chain shifts.
    always_comb begin
        rb_acc_d           = rb_acc_q;
        rb_acc_d[rb_idx_q] = cfg_scan_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_idx_q <= '0;
            rb_acc_q <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (accept) begin
                rb_idx_q <= '0;
                rb_acc_q <= '0;
            end else if (state_q == StShift) begin
                rb_idx_q <= rb_idx_q + IW'(1);
                rb_acc_q <= rb_acc_d;
                if (last_bit) begin
                    rb_data  <= rb_acc_d;
                    rb_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_scan_in;

    assign unused_scan_in = cfg_scan_in;
    assign rb_data        = '0;
    assign rb_valid       = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_config_loader.sv
// Random-stimulus bench for fpga_config_loader against a cycle-timeline model
// built from word/stall lists, with a behavioural 12-bit scan chain attached.
module tb_fpga_config_loader;

    localparam int L  = 12;
    localparam int W  = 8;
    localparam int NW = (L + W - 1) / W;

    typedef struct {
        bit           st;
        bit           iv;
        logic [W-1:0] d;
        bit           rdy;
        bit           bsy;
        bit           dn;
        bit           en;
        bit           so;
        bit           rbv;
        logic [W-1:0] rbd;
    } ent_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         cfg_scan_out;
    logic         cfg_scan_en;
    logic         cfg_scan_in;
    logic         busy;
    logic         done;
    logic [W-1:0] rb_data;
    logic         rb_valid;

    int ncmp = 0;
    int nerr = 0;

    ent_t tl[$];
    ent_t exp_q[$];
    ent_t ce;
    logic [W-1:0] rb_seen[$];

    logic [L-1:0] chain = 12'h3C6;
    int cyc     = 0;
    int t_start = 0;
    int t_done  = 0;
    int n_en    = 0;
    int n_hs    = 0;
    bit done_n  = 1'b0;

    fpga_config_loader #(
        .CHAIN_LEN (L),
        .WORD_W    (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cfg_scan_out (cfg_scan_out),
        .cfg_scan_en  (cfg_scan_en),
        .cfg_scan_in  (cfg_scan_in),
        .busy         (busy),
        .done         (done),
        .rb_data      (rb_data),
        .rb_valid     (rb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached scan chain: head enters at the top, tail is bit 0.
    always @(posedge clk) begin
        if (cfg_scan_en) chain <= {cfg_scan_out, chain[L-1:1]};
    end
    assign cfg_scan_in = chain[0];

    always @(posedge clk) begin
        if (start && !busy) t_start <= cyc;
        cyc <= cyc + 1;
        if (cfg_scan_en) n_en <= n_en + 1;
        if (in_valid && in_ready) n_hs <= n_hs + 1;
    end

    always @(negedge clk) begin
        if (done && !done_n) t_done <= cyc;
        done_n <= done;
        if (rb_valid) rb_seen.push_back(rb_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ent_t blank();
        ent_t e;
        e.st = 0; e.iv = 0; e.d = '0; e.rdy = 0; e.bsy = 0; e.dn = 0;
        e.en = 0; e.so = 0; e.rbv = 0; e.rbd = '0;
        return e;
    endfunction

    function automatic int nbits(input int i);
        return (i == NW - 1) ? L - (NW - 1) * W : W;
    endfunction

    // Expected per-cycle timeline of one load: start, then per word its stalls,
    // one handshake and n shift cycles, then a few DONE cycles.
    task automatic build(input logic [NW*W-1:0] wv, input logic [NW*4-1:0] stalls,
                         input bit noise, input bit in_done);
        ent_t e;
        bit pend;
        logic [W-1:0] pd;
        int base;
        logic [L-1:0] old;
        old  = chain;
        pend = 0;
        pd   = '0;
        base = 0;
        e = blank(); e.st = 1; e.dn = in_done;
        tl.push_back(e);
        for (int i = 0; i < NW; i++) begin
            int n;
            n = nbits(i);
            for (int s = 0; s <= int'(stalls[i*4+:4]); s++) begin
                e = blank(); e.rdy = 1; e.bsy = 1;
                if (s == int'(stalls[i*4+:4])) begin
                    e.iv = 1; e.d = wv[i*W+:W];
                end else if (noise) begin
                    e.d = W'($urandom); e.st = 1'($urandom);
                end
                if (pend) begin e.rbv = 1; e.rbd = pd; pend = 0; end
                tl.push_back(e);
            end
            pd = '0;
            for (int k = 0; k < n; k++) begin
                e = blank(); e.bsy = 1; e.en = 1; e.so = wv[i*W+k];
                if (noise) begin
                    e.iv = 1'($urandom); e.d = W'($urandom); e.st = 1'($urandom);
                end
                pd[k] = old[base+k];
                tl.push_back(e);
            end
            base += n;
            pend = 1;
        end
        for (int j = 0; j < 3; j++) begin
            e = blank(); e.dn = 1;
            if (noise) begin e.iv = 1'($urandom); e.d = W'($urandom); end
            if (pend) begin e.rbv = 1; e.rbd = pd; pend = 0; end
            tl.push_back(e);
        end
    endtask

    task automatic run(input int cnt);
        ent_t e;
        int left;
        left = cnt;
        while (tl.size() != 0 && left != 0) begin
            e = tl.pop_front();
            @(negedge clk);
            start = e.st; in_valid = e.iv; in_data = e.d;
            exp_q.push_back(e);
            left--;
        end
        #3;
    endtask

    always @(negedge clk) begin
        #2;
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            chk("in_ready", in_ready, ce.rdy);
            chk("busy", busy, ce.bsy);
            chk("done", done, ce.dn);
            chk("scan_en", cfg_scan_en, ce.en);
            if (ce.en) chk("scan_out", cfg_scan_out, ce.so);
`ifdef CFG_READBACK_EN
            chk("rb_valid", rb_valid, ce.rbv);
            if (ce.rbv) chk("rb_data", rb_data, ce.rbd);
`else
            chk("rb_valid", rb_valid, 0);
            chk("rb_data", rb_data, 0);
`endif
        end
    end

    task automatic load(input logic [NW*W-1:0] wv, input logic [NW*4-1:0] stalls,
                        input bit noise, input bit in_done, input int exp_lat,
                        input logic [L-1:0] exp_chain);
        int en0, hs0;
        en0 = n_en;
        hs0 = n_hs;
        build(wv, stalls, noise, in_done);
        run(-1);
        chk("chain", chain, exp_chain);
        chk("done_latency", t_done - t_start, exp_lat);
        chk("scan_en_cycles", n_en - en0, L);
        chk("handshakes", n_hs - hs0, NW);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NW*W-1:0] rw;
        logic [NW*4-1:0] rs;
        int sum;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_scan_en", cfg_scan_en, 0);
        chk("rst_scan_out", cfg_scan_out, 0);
        chk("rst_rb_valid", rb_valid, 0);
        chk("rst_rb_data", rb_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1 + NWORDS + CHAIN_LEN = 15 cycles from start cycle to first done cycle.
        load({8'h0C, 8'hA5}, 8'h00, 0, 0, 15, 12'hCA5);
        load({8'h00, 8'h00}, 8'h00, 0, 1, 15, 12'h000);
`ifdef CFG_READBACK_EN
        chk("rb_word0", rb_seen[rb_seen.size()-2], 8'hA5);
        chk("rb_word1", rb_seen[rb_seen.size()-1], 8'h0C);
`else
        chk("rb_pulses", rb_seen.size(), 0);
`endif
        // Five stall cycles before word 2 push done out by five.
        load({8'h0C, 8'hA5}, 8'h50, 0, 1, 20, 12'hCA5);
        // Upper nibble of the last word is dropped; start/in_valid noise in SHIFT.
        load({8'hFC, 8'hA5}, 8'h00, 1, 1, 15, 12'hCA5);

        // Reset in the middle of word 1's shift.
        build({8'h0F, 8'h77}, 8'h00, 0, 1);
        run(6);
        tl.delete();
        rst = 1'b1;
        #1;
        chk("midrst_scan_en", cfg_scan_en, 0);
        chk("midrst_scan_out", cfg_scan_out, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rb_valid", rb_valid, 0);
        start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load({8'h05, 8'h33}, 8'h00, 0, 0, 15, 12'h533);

        for (int r = 0; r < 20; r++) begin
            sum = 0;
            for (int i = 0; i < NW; i++) begin
                rw[i*W+:W] = W'($urandom);
                rs[i*4+:4] = 4'($urandom_range(3));
                sum += int'(rs[i*4+:4]);
            end
            load(rw, rs, 1, 1, 1 + NW + L + sum, rw[L-1:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
